layer_sample_sequencer: RTL and testbench

//  Sequences one spike-layer instance through successive input samples. Accepts a

---
 rtl/layer_sample_sequencer.sv | 135 +++++++++++++
 tb/tb_layer_sample_sequencer.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/layer_sample_sequencer.sv
// Sequences one spike-layer instance through input samples: accepts a spike-time
// vector, sweeps time_val over one sample window, captures the layer result and
// returns it over a back-pressurable valid/ready handshake.
module layer_sample_sequencer #(
  parameter int unsigned TIME_PERIOD = 8,
  parameter int unsigned TW          = 4,
  parameter int unsigned NUM_SPIKES  = 16,
  parameter int unsigned NW          = 4,
  parameter int unsigned CNT_W       = 16
) (
  input  logic                     clk,
  input  logic                     rst_l,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [NUM_SPIKES*TW-1:0] in_spike_times,
  input  logic                     in_train,
  input  logic                     abort,
  output logic [NUM_SPIKES*TW-1:0] layer_spike_times,
  output logic [TW-1:0]            layer_time_val,
  output logic                     layer_training,
  input  logic [NW-1:0]            layer_winner,
  input  logic [TW-1:0]            layer_out_time,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [NW-1:0]            out_winner,
  output logic [TW-1:0]            out_time,
  output logic                     out_no_fire,
  output logic [CNT_W-1:0]         sample_count
);

  typedef enum logic [1:0] {StIdle, StRun, StCapture, StDone} state_e;

  localparam logic [TW-1:0] LastT = TW'(TIME_PERIOD - 1);
  // One extra bit so the no-fire compare is safe even if TIME_PERIOD fills TW.
  localparam logic [TW:0] PeriodExt = (TW + 1)'(TIME_PERIOD);

  state_e                     state_q, state_d;
  logic [TW-1:0]              time_q, time_d;
  logic [NUM_SPIKES*TW-1:0]   spikes_q, spikes_d;
  logic                       train_q, train_d;
  logic [NW-1:0]              winner_q, winner_d;
  logic [TW-1:0]              otime_q, otime_d;
  logic                       no_fire_q, no_fire_d;
  logic [CNT_W-1:0]           count_q, count_d;

  // Next-state logic: abort outside IDLE overrides the normal sequence.
  always_comb begin
    state_d   = state_q;
    time_d    = time_q;
    spikes_d  = spikes_q;
    train_d   = train_q;
    winner_d  = winner_q;
    otime_d   = otime_q;
    no_fire_d = no_fire_q;
    count_d   = count_q;

    if (abort && (state_q != StIdle)) begin
      // Drop the sample without capturing or counting it.
      state_d = StIdle;
      time_d  = '0;
      train_d = 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          time_d = '0;
          if (in_valid) begin
            spikes_d = in_spike_times;
            train_d  = in_train;
            state_d  = StRun;
          end
        end
        StRun: begin
          // Last window step holds its value through CAPTURE.
          if (time_q == LastT) begin
            state_d = StCapture;
          end else begin
            time_d = time_q + TW'(1);
          end
        end
        StCapture: begin
          winner_d  = layer_winner;
          otime_d   = layer_out_time;
          no_fire_d = ({1'b0, layer_out_time} >= PeriodExt);
          train_d   = 1'b0;
          time_d    = '0;
          state_d   = StDone;
        end
        StDone: begin
          if (out_ready) begin
            count_d = count_q + CNT_W'(1);
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_l) begin
      state_q   <= StIdle;
      time_q    <= '0;
      spikes_q  <= '0;
      train_q   <= 1'b0;
      winner_q  <= '0;
      otime_q   <= '0;
      no_fire_q <= 1'b0;
      count_q   <= '0;
    end else begin
      state_q   <= state_d;
      time_q    <= time_d;
      spikes_q  <= spikes_d;
      train_q   <= train_d;
      winner_q  <= winner_d;
      otime_q   <= otime_d;
      no_fire_q <= no_fire_d;
      count_q   <= count_d;
    end
  end

  // Outputs are decoded from state or driven straight from registers.
  always_comb begin
    in_ready          = (state_q == StIdle);
    out_valid         = (state_q == StDone);
    layer_spike_times = spikes_q;
    layer_time_val    = time_q;
    layer_training    = train_q;
    out_winner        = winner_q;
    out_time          = otime_q;
    out_no_fire       = no_fire_q;
    sample_count      = count_q;
  end

endmodule

// File: tb/tb_layer_sample_sequencer.sv
// Scoreboard bench for layer_sample_sequencer: stimulus pushes the expected
// result of each completed sample, a monitor pops and compares on handshake.
module tb_layer_sample_sequencer;

  localparam int TP    = 8;
  localparam int TW    = 4;
  localparam int NS    = 16;
  localparam int NW    = 4;
  localparam int CNT_W = 4;  // small counter so wrap-around is reachable quickly

  logic              clk;
  logic              rst_l;
  logic              in_valid;
  logic              in_ready;
  logic [NS*TW-1:0]  in_spike_times;
  logic              in_train;
  logic              abort;
  logic [NS*TW-1:0]  layer_spike_times;
  logic [TW-1:0]     layer_time_val;
  logic              layer_training;
  logic [NW-1:0]     layer_winner;
  logic [TW-1:0]     layer_out_time;
  logic              out_valid;
  logic              out_ready;
  logic [NW-1:0]     out_winner;
  logic [TW-1:0]     out_time;
  logic              out_no_fire;
  logic [CNT_W-1:0]  sample_count;

  layer_sample_sequencer #(
    .TIME_PERIOD(TP),
    .TW         (TW),
    .NUM_SPIKES (NS),
    .NW         (NW),
    .CNT_W      (CNT_W)
  ) dut (
    .clk              (clk),
    .rst_l            (rst_l),
    .in_valid         (in_valid),
    .in_ready         (in_ready),
    .in_spike_times   (in_spike_times),
    .in_train         (in_train),
    .abort            (abort),
    .layer_spike_times(layer_spike_times),
    .layer_time_val   (layer_time_val),
    .layer_training   (layer_training),
    .layer_winner     (layer_winner),
    .layer_out_time   (layer_out_time),
    .out_valid        (out_valid),
    .out_ready        (out_ready),
    .out_winner       (out_winner),
    .out_time         (out_time),
    .out_no_fire      (out_no_fire),
    .sample_count     (sample_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [NW-1:0] w;
    logic [TW-1:0] t;
    logic          nf;
    int            cnt;
  } exp_t;

  exp_t sb[$];
  int   errors = 0;
  int   checks = 0;
  int   exp_count = 0;  // reference count of delivered results, modulo 2^CNT_W

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: compare every delivered result against the oldest expectation.
  always @(negedge clk) begin
    exp_t e;
    if (rst_l && out_valid && out_ready && !abort) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL sb_empty: got result %0h/%0h expected none", out_winner, out_time);
      end else begin
        e = sb.pop_front();
        chk("sb_winner", out_winner, e.w);
        chk("sb_time", out_time, e.t);
        chk("sb_no_fire", out_no_fire, e.nf);
        chk("sb_count_before", sample_count, e.cnt);
      end
    end
  end

  task automatic chk_reset_values(input string tag);
    chk({tag, "_in_ready"}, in_ready, 1);
    chk({tag, "_out_valid"}, out_valid, 0);
    chk({tag, "_spikes"}, layer_spike_times, 0);
    chk({tag, "_time_val"}, layer_time_val, 0);
    chk({tag, "_training"}, layer_training, 0);
    chk({tag, "_winner"}, out_winner, 0);
    chk({tag, "_out_time"}, out_time, 0);
    chk({tag, "_no_fire"}, out_no_fire, 0);
    chk({tag, "_count"}, sample_count, 0);
  endtask

  // kind: 0 normal, 1 abort at cycle stop_at, 2 reset at cycle stop_at.
  // Cycle c after accept: c<TP RUN, c==TP CAPTURE, c==TP+1 first DONE cycle.
  // Entry/exit point: just after a rising edge.
  task automatic run_sample(input logic [63:0] sp, input logic tr, input logic [NW-1:0] w,
                            input logic [TW-1:0] ot, input int stall, input int kind,
                            input int stop_at);
    int   waited;
    exp_t e;
    waited = 0;
    in_valid = 1'b1;
    in_spike_times = sp;
    in_train = tr;
    layer_winner = w;
    layer_out_time = ot;
    @(negedge clk);
    while (!in_ready && waited < 20) begin
      @(negedge clk);
      waited++;
    end
    chk("accept_ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    in_spike_times = {$urandom, $urandom};  // sequencer must keep the latched copy
    in_train = ~tr;
    if (kind == 0) begin
      e.w = w;
      e.t = ot;
      e.nf = (int'(ot) >= TP);
      e.cnt = exp_count;
      sb.push_back(e);
    end
    for (int c = 0; c < TP + 2; c++) begin
      if (c == TP + 1) begin
        // Capture already happened; the layer may now change freely.
        layer_winner = ~w;
        layer_out_time = ~ot;
      end
      if (kind == 1 && stop_at == c) begin
        abort = 1'b1;
        out_ready = (c == TP + 1);
      end
      if (kind == 2 && stop_at == c) rst_l = 1'b0;
      @(negedge clk);
      chk("run_time_val", layer_time_val, (c < TP) ? c : ((c == TP) ? TP - 1 : 0));
      chk("run_training", layer_training, (c <= TP) ? tr : 1'b0);
      chk("latency_valid", out_valid, (c == TP + 1));
      chk("run_in_ready", in_ready, 0);
      chk("hold_spikes", layer_spike_times, sp);
      @(posedge clk); #1;
      if (kind == 1 && stop_at == c) begin
        abort = 1'b0;
        out_ready = 1'b0;
        @(negedge clk);
        chk("abort_in_ready", in_ready, 1);
        chk("abort_out_valid", out_valid, 0);
        chk("abort_training", layer_training, 0);
        chk("abort_time_val", layer_time_val, 0);
        chk("abort_count", sample_count, exp_count);
        @(posedge clk); #1;
        return;
      end
      if (kind == 2 && stop_at == c) begin
        @(negedge clk);
        exp_count = 0;
        chk_reset_values("midrun_rst");
        @(posedge clk); #1;
        rst_l = 1'b1;
        return;
      end
    end
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      chk("stall_valid", out_valid, 1);
      chk("stall_in_ready", in_ready, 0);
      chk("stall_winner", out_winner, w);
      chk("stall_time", out_time, ot);
      chk("stall_no_fire", out_no_fire, (int'(ot) >= TP));
      @(posedge clk); #1;
    end
    out_ready = 1'b1;
    @(negedge clk);
    @(posedge clk); #1;
    out_ready = 1'b0;
    exp_count = (exp_count + 1) % (1 << CNT_W);
    @(negedge clk);
    chk("post_hs_valid", out_valid, 0);
    chk("post_hs_in_ready", in_ready, 1);
    chk("post_hs_count", sample_count, exp_count);
    @(posedge clk); #1;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int kind;
    int stop_at;
    rst_l = 1'b0;
    in_valid = 1'b0;
    in_spike_times = '0;
    in_train = 1'b0;
    abort = 1'b0;
    out_ready = 1'b0;
    layer_winner = '0;
    layer_out_time = '0;
    repeat (2) begin
      @(posedge clk); #1;
    end
    @(negedge clk);
    chk_reset_values("reset");
    @(posedge clk); #1;
    rst_l = 1'b1;

    // Directed cases.
    run_sample({$urandom, $urandom}, 1'b1, 4'd3, 4'd5, 0, 0, 0);
    chk("first_count", sample_count, 1);
    run_sample({$urandom, $urandom}, 1'b0, 4'd7, 4'd8, 20, 0, 0);
    run_sample({$urandom, $urandom}, 1'b1, 4'd2, 4'd1, 0, 1, 4);
    run_sample({$urandom, $urandom}, 1'b1, 4'd9, 4'd15, 1, 0, 0);
    run_sample({$urandom, $urandom}, 1'b1, 4'd1, 4'd2, 0, 1, TP);
    run_sample({$urandom, $urandom}, 1'b0, 4'd4, 4'd6, 0, 1, TP + 1);

    // Randomized samples.
    for (int i = 0; i < 30; i++) begin
      kind = ($urandom_range(0, 4) == 0) ? 1 : 0;
      stop_at = $urandom_range(0, TP + 1);
      run_sample({$urandom, $urandom}, 1'($urandom), NW'($urandom), TW'($urandom),
                 $urandom_range(0, 5), kind, stop_at);
    end

    // Drive the counter to its maximum, then one more handshake must wrap it.
    for (int i = 0; i < (1 << CNT_W) && exp_count != (1 << CNT_W) - 1; i++) begin
      run_sample({$urandom, $urandom}, 1'b0, NW'($urandom), TW'($urandom), 0, 0, 0);
    end
    chk("count_at_max", sample_count, (1 << CNT_W) - 1);
    run_sample({$urandom, $urandom}, 1'b1, 4'd5, 4'd3, 0, 0, 0);
    chk("count_wrap", sample_count, 0);

    // Reset in the middle of a window, then confirm normal operation resumes.
    run_sample({$urandom, $urandom}, 1'b1, 4'd6, 4'd2, 0, 0, 0);
    run_sample({$urandom, $urandom}, 1'b1, 4'd8, 4'd4, 0, 2, 3);
    run_sample({$urandom, $urandom}, 1'b1, 4'd10, 4'd7, 2, 0, 0);
    chk("count_after_reset", sample_count, 1);

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
